// File: rtl/cpu_ctrl_pkg.sv
// Shared control definitions for the next-PC sequencer: branch-op encodings,
// sequencer states and reset defaults.
package cpu_ctrl_pkg;

    typedef enum logic [2:0] {
        BR_NONE  = 3'b000,
        BR_BMN   = 3'b001,
        BR_BRZ   = 3'b010,
        BR_BZ    = 3'b011,
        BR_JMOR  = 3'b100,
        BR_JALM  = 3'b101,
        BR_JSPAL = 3'b110,
        BR_RSVD  = 3'b111
    } br_op_e;

    typedef enum logic [1:0] {
        ST_RUN  = 2'd0,
        ST_PUSH = 2'd1,
        ST_READ = 2'd2
    } seq_state_e;

    localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;
    localparam logic [4:0]  LINK_REG_DEFAULT = 5'd31;

    // Pseudo-direct jump target: region bits of the next PC plus word index.
    function automatic logic [31:0] bz_target(input logic [31:0] pc4,
                                              input logic [25:0] diraddr);
        return {pc4[31:28], diraddr, 2'b00};
    endfunction

endpackage

// File: rtl/pc_sequencer_if.sv
// Data-memory request/acknowledge port used for indirect targets and pushes.
interface pc_sequencer_if;
    logic        mem_req;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic        mem_ack;
    logic [31:0] mem_rdata;

    modport master (
        output mem_req, mem_we, mem_addr, mem_wdata,
        input  mem_ack, mem_rdata
    );

    modport slave (
        input  mem_req, mem_we, mem_addr, mem_wdata,
        output mem_ack, mem_rdata
    );
endinterface

// File: rtl/status_flags.sv
// N/Z/V status register with write enable and synchronous reset.
module status_flags (
    input  logic clk,
    input  logic reset,
    input  logic we_i,
    input  logic n_i,
    input  logic z_i,
    input  logic v_i,
    output logic n_o,
    output logic z_o,
    output logic v_o
);
    logic n_q, z_q, v_q;

    // Load the ALU flags whenever a write is requested.
    always_ff @(posedge clk) begin
        if (reset) begin
            n_q <= 1'b0;
            z_q <= 1'b0;
            v_q <= 1'b0;
        end else if (we_i) begin
            n_q <= n_i;
            z_q <= z_i;
            v_q <= v_i;
        end
    end

    assign n_o = n_q;
    assign z_o = z_q;
    assign v_o = v_q;
endmodule

// File: rtl/pc_sequencer.sv
// Multi-cycle next-PC controller: owns the PC and status flags, resolves the
// custom branch/jump ops and fetches indirect targets / pushes return
// addresses over the data-memory port, stalling fetch meanwhile.
module pc_sequencer
    import cpu_ctrl_pkg::*;
#(
    parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT,
    parameter logic [4:0]  LINK_REG = LINK_REG_DEFAULT
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   instr_valid,
    input  logic [2:0]             br_op,
    input  logic [25:0]            j_diraddr,
    input  logic [31:0]            reg_s,
    input  logic [31:0]            ea,
    input  logic [31:0]            sp_in,
    input  logic                   flag_we,
    input  logic                   alu_n,
    input  logic                   alu_z,
    input  logic                   alu_v,
    pc_sequencer_if.master         mem,
    output logic [31:0]            pc,
    output logic                   stall,
    output logic                   link_we,
    output logic [4:0]             link_rd,
    output logic [31:0]            link_data,
    output logic                   sp_we,
    output logic [31:0]            sp_out,
    output logic                   flag_n,
    output logic                   flag_z,
    output logic                   flag_v
);

    br_op_e      op;
    logic [31:0] pc4;

    seq_state_e  state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic [31:0] ea_q, ea_d;          // indirect target address held across a push
    logic [31:0] ret_q, ret_d;        // return address (pc+4 of the jump)
    logic        jalm_q, jalm_d;      // current read belongs to a jalm
    logic        req_q, req_d;
    logic        we_q, we_d;
    logic [31:0] addr_q, addr_d;
    logic [31:0] wdata_q, wdata_d;
    logic        link_we_q, link_we_d;
    logic [31:0] link_data_q, link_data_d;
    logic        sp_we_q, sp_we_d;
    logic [31:0] sp_out_q, sp_out_d;
    logic        stall_c;

    assign op  = br_op_e'(br_op);
    assign pc4 = pc_q + 32'd4;

    status_flags u_flags (
        .clk   (clk),
        .reset (reset),
        .we_i  (flag_we),
        .n_i   (alu_n),
        .z_i   (alu_z),
        .v_i   (alu_v),
        .n_o   (flag_n),
        .z_o   (flag_z),
        .v_o   (flag_v)
    );

    // Next-state, next-PC and memory-request decisions; branches test the
    // registered flags, so a same-cycle flag write is not yet visible.
    always_comb begin
        state_d     = state_q;
        pc_d        = pc_q;
        ea_d        = ea_q;
        ret_d       = ret_q;
        jalm_d      = jalm_q;
        req_d       = req_q;
        we_d        = we_q;
        addr_d      = addr_q;
        wdata_d     = wdata_q;
        link_we_d   = 1'b0;
        link_data_d = link_data_q;
        sp_we_d     = 1'b0;
        sp_out_d    = sp_out_q;
        stall_c     = 1'b0;

        case (state_q)
            ST_RUN: begin
                pc_d = pc4;
                if (instr_valid) begin
                    case (op)
                        BR_BMN, BR_JMOR, BR_JALM: begin
                            // bmn only goes to memory when N is set
                            if (op != BR_BMN || flag_n) begin
                                stall_c = 1'b1;
                                pc_d    = pc_q;
                                ret_d   = pc4;
                                jalm_d  = (op == BR_JALM);
                                req_d   = 1'b1;
                                we_d    = 1'b0;
                                addr_d  = ea;
                                state_d = ST_READ;
                            end
                        end
                        BR_BRZ: begin
                            pc_d = flag_z ? reg_s : pc4;
                        end
                        BR_BZ: begin
                            pc_d = flag_z ? pc4 : bz_target(pc4, j_diraddr);
                        end
                        BR_JSPAL: begin
                            stall_c = 1'b1;
                            pc_d    = pc_q;
                            ret_d   = pc4;
                            ea_d    = ea;
                            jalm_d  = 1'b0;
                            req_d   = 1'b1;
                            we_d    = 1'b1;
                            addr_d  = sp_in - 32'd4;
                            wdata_d = pc4;
                            state_d = ST_PUSH;
                        end
                        default: begin
                            pc_d = pc4;
                        end
                    endcase
                end
            end
            ST_PUSH: begin
                stall_c = 1'b1;
                if (mem.mem_ack) begin
                    // push done: publish new SP and turn the request into the target read
                    sp_we_d  = 1'b1;
                    sp_out_d = sp_in - 32'd4;
                    we_d     = 1'b0;
                    addr_d   = ea_q;
                    state_d  = ST_READ;
                end
            end
            ST_READ: begin
                stall_c = 1'b1;
                if (mem.mem_ack) begin
                    pc_d    = mem.mem_rdata;
                    req_d   = 1'b0;
                    state_d = ST_RUN;
                    if (jalm_q) begin
                        link_we_d   = 1'b1;
                        link_data_d = ret_q;
                    end
                end
            end
            default: begin
                state_d = ST_RUN;
            end
        endcase
    end

    // State and output registers; reset abandons any outstanding transaction.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= ST_RUN;
            pc_q        <= RESET_PC;
            ea_q        <= 32'd0;
            ret_q       <= 32'd0;
            jalm_q      <= 1'b0;
            req_q       <= 1'b0;
            we_q        <= 1'b0;
            addr_q      <= 32'd0;
            wdata_q     <= 32'd0;
            link_we_q   <= 1'b0;
            link_data_q <= 32'd0;
            sp_we_q     <= 1'b0;
            sp_out_q    <= 32'd0;
        end else begin
            state_q     <= state_d;
            pc_q        <= pc_d;
            ea_q        <= ea_d;
            ret_q       <= ret_d;
            jalm_q      <= jalm_d;
            req_q       <= req_d;
            we_q        <= we_d;
            addr_q      <= addr_d;
            wdata_q     <= wdata_d;
            link_we_q   <= link_we_d;
            link_data_q <= link_data_d;
            sp_we_q     <= sp_we_d;
            sp_out_q    <= sp_out_d;
        end
    end

    assign pc            = pc_q;
    assign stall         = stall_c;
    assign mem.mem_req   = req_q;
    assign mem.mem_we    = we_q;
    assign mem.mem_addr  = addr_q;
    assign mem.mem_wdata = wdata_q;
    assign link_we       = link_we_q;
    assign link_rd       = LINK_REG;
    assign link_data     = link_data_q;
    assign sp_we         = sp_we_q;
    assign sp_out        = sp_out_q;

endmodule

// File: tb/tb_pc_sequencer.sv
// Self-checking bench for pc_sequencer: directed scenarios plus randomized
// instructions compared against a behavioural next-PC model.
module tb_pc_sequencer;

    logic        clk = 1'b0;
    logic        reset;
    logic        instr_valid;
    logic [2:0]  br_op;
    logic [25:0] j_diraddr;
    logic [31:0] reg_s, ea, sp_in;
    logic        flag_we, alu_n, alu_z, alu_v;
    logic [31:0] pc;
    logic        stall, link_we, sp_we;
    logic [4:0]  link_rd;
    logic [31:0] link_data, sp_out;
    logic        flag_n, flag_z, flag_v;

    pc_sequencer_if mem_bus ();

    pc_sequencer dut (
        .clk         (clk),
        .reset       (reset),
        .instr_valid (instr_valid),
        .br_op       (br_op),
        .j_diraddr   (j_diraddr),
        .reg_s       (reg_s),
        .ea          (ea),
        .sp_in       (sp_in),
        .flag_we     (flag_we),
        .alu_n       (alu_n),
        .alu_z       (alu_z),
        .alu_v       (alu_v),
        .mem         (mem_bus),
        .pc          (pc),
        .stall       (stall),
        .link_we     (link_we),
        .link_rd     (link_rd),
        .link_data   (link_data),
        .sp_we       (sp_we),
        .sp_out      (sp_out),
        .flag_n      (flag_n),
        .flag_z      (flag_z),
        .flag_v      (flag_v)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;

    // reference model state
    logic [31:0] m_pc;
    logic        m_n, m_z, m_v;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset;
        reset = 1'b1;
        instr_valid = 1'b0;
        flag_we = 1'b0;
        mem_bus.mem_ack = 1'b0;
        tick();
        reset = 1'b0;
        m_pc = 32'h0;
        m_n = 1'b0; m_z = 1'b0; m_v = 1'b0;
    endtask

    // Serve one memory request: `waits` cycles without ack, then ack.
    task automatic serve(input int waits, input logic [31:0] rdata,
                         inout int stalls, inout int link_cnt, inout int sp_cnt);
        for (int w = 0; w < waits; w++) begin
            mem_bus.mem_ack = 1'b0;
            #1;
            if (stall) stalls++;
            tick();
            if (link_we) link_cnt++;
            if (sp_we) sp_cnt++;
        end
        mem_bus.mem_ack = 1'b1;
        mem_bus.mem_rdata = rdata;
        #1;
        if (stall) stalls++;
        tick();
        mem_bus.mem_ack = 1'b0;
        if (link_we) link_cnt++;
        if (sp_we) sp_cnt++;
    endtask

    // Execute one instruction from RUN until the sequencer is back in RUN,
    // and compare everything observable against the model.
    task automatic run_instr(input string tag, input logic v, input logic [2:0] op,
                             input logic [25:0] j, input logic [31:0] rs,
                             input logic [31:0] e, input logic [31:0] sp,
                             input logic fwe, input logic [2:0] nzv,
                             input int waits, input logic [31:0] rdata);
        logic [31:0] pc4, exp_pc;
        logic mem_op, push, link;
        int stalls, exp_stalls, link_cnt, sp_cnt;
        pc4    = m_pc + 32'd4;
        push   = v && (op == 3'd6);
        link   = v && (op == 3'd5);
        mem_op = v && ((op == 3'd4) || link || push || ((op == 3'd1) && m_n));
        if (mem_op)                    exp_pc = rdata;
        else if (v && op == 3'd2)      exp_pc = m_z ? rs : pc4;
        else if (v && op == 3'd3)      exp_pc = m_z ? pc4 : {pc4[31:28], j, 2'b00};
        else                           exp_pc = pc4;
        exp_stalls = !mem_op ? 0 : (push ? 1 + 2 * (waits + 1) : 1 + waits + 1);

        instr_valid = v; br_op = op; j_diraddr = j; reg_s = rs; ea = e; sp_in = sp;
        flag_we = fwe; {alu_n, alu_z, alu_v} = nzv;
        mem_bus.mem_ack = 1'b0;
        stalls = 0; link_cnt = 0; sp_cnt = 0;
        #1;
        if (stall) stalls++;
        tick();
        flag_we = 1'b0;
        if (link_we) link_cnt++;
        if (sp_we) sp_cnt++;
        if (mem_op) begin
            if (push) begin
                chk({tag, "_push_req"},   32'(mem_bus.mem_req), 32'd1);
                chk({tag, "_push_we"},    32'(mem_bus.mem_we), 32'd1);
                chk({tag, "_push_addr"},  mem_bus.mem_addr, sp - 32'd4);
                chk({tag, "_push_wdata"}, mem_bus.mem_wdata, pc4);
                serve(waits, 32'h0, stalls, link_cnt, sp_cnt);
                chk({tag, "_sp_out"}, sp_out, sp - 32'd4);
            end
            chk({tag, "_read_req"},  32'(mem_bus.mem_req), 32'd1);
            chk({tag, "_read_we"},   32'(mem_bus.mem_we), 32'd0);
            chk({tag, "_read_addr"}, mem_bus.mem_addr, e);
            serve(waits, rdata, stalls, link_cnt, sp_cnt);
            chk({tag, "_req_drop"}, 32'(mem_bus.mem_req), 32'd0);
            if (link) begin
                chk({tag, "_link_data"}, link_data, pc4);
                chk({tag, "_link_rd"}, 32'(link_rd), 32'd31);
            end
        end
        m_pc = exp_pc;
        if (fwe) {m_n, m_z, m_v} = nzv;
        chk({tag, "_stall_cycles"}, 32'(stalls), 32'(exp_stalls));
        chk({tag, "_pc"}, pc, m_pc);
        chk({tag, "_flags"}, {29'd0, flag_n, flag_z, flag_v}, {29'd0, m_n, m_z, m_v});
        chk({tag, "_link_pulses"}, 32'(link_cnt), link ? 32'd1 : 32'd0);
        chk({tag, "_sp_pulses"}, 32'(sp_cnt), push ? 32'd1 : 32'd0);
        $display("instr %s v=%0b op=%0d pc=%h stalls=%0d", tag, v, op, pc, stalls);
    endtask

    initial begin
        reset = 1'b1; instr_valid = 1'b0; br_op = 3'd0; j_diraddr = '0;
        reg_s = '0; ea = '0; sp_in = '0; flag_we = 1'b0;
        alu_n = 1'b0; alu_z = 1'b0; alu_v = 1'b0;
        mem_bus.mem_ack = 1'b0; mem_bus.mem_rdata = '0;
        tick();
        do_reset();

        // reset state
        chk("rst_pc", pc, 32'h0);
        chk("rst_stall", 32'(stall), 32'd0);
        chk("rst_req", 32'(mem_bus.mem_req), 32'd0);
        chk("rst_we", 32'(mem_bus.mem_we), 32'd0);
        chk("rst_addr", mem_bus.mem_addr, 32'd0);
        chk("rst_wdata", mem_bus.mem_wdata, 32'd0);
        chk("rst_pulses", {30'd0, link_we, sp_we}, 32'd0);
        chk("rst_flags", {29'd0, flag_n, flag_z, flag_v}, 32'd0);
        $display("reset pc=%h", pc);

        // sequential fetch, then bz with same-cycle flag write (old Z=0 -> taken)
        for (int i = 0; i < 4; i++)
            run_instr("none", 1'b1, 3'd0, '0, '0, '0, '0, 1'b0, 3'b000, 0, '0);
        run_instr("bz_oldflags", 1'b1, 3'd3, 26'h40, '0, '0, '0, 1'b1, 3'b010, 0, '0);
        // brz taken with Z=1, then not taken with Z=0
        run_instr("brz_taken", 1'b1, 3'd2, '0, 32'h100, '0, '0, 1'b0, 3'b000, 0, '0);
        run_instr("set_z0", 1'b1, 3'd0, '0, '0, '0, '0, 1'b1, 3'b000, 0, '0);
        run_instr("brz_not", 1'b1, 3'd2, '0, 32'h100, '0, '0, 1'b0, 3'b000, 0, '0);
        run_instr("op111", 1'b1, 3'd7, '0, 32'h700, 32'h7000, '0, 1'b0, 3'b000, 0, '0);

        // jalm at 0x20 with two wait cycles (four stall cycles)
        do_reset();
        for (int i = 0; i < 8; i++)
            run_instr("none", 1'b1, 3'd0, '0, '0, '0, '0, 1'b0, 3'b000, 0, '0);
        run_instr("jalm", 1'b1, 3'd5, '0, '0, 32'h200, '0, 1'b0, 3'b000, 2, 32'h400);

        // jspal at 0x30 with immediate acks
        do_reset();
        for (int i = 0; i < 12; i++)
            run_instr("none", 1'b1, 3'd0, '0, '0, '0, '0, 1'b0, 3'b000, 0, '0);
        run_instr("jspal", 1'b1, 3'd6, '0, '0, 32'h300, 32'h1000, 1'b0, 3'b000, 0, 32'h500);

        // bmn with N clear (no access) then set (indirect read)
        run_instr("bmn_n0", 1'b1, 3'd1, '0, '0, 32'h800, '0, 1'b1, 3'b100, 0, 32'h900);
        run_instr("bmn_n1", 1'b1, 3'd1, '0, '0, 32'h800, '0, 1'b0, 3'b000, 1, 32'h900);

        // randomized instructions against the model
        for (int i = 0; i < 60; i++) begin
            run_instr("rand",
                      ($urandom_range(0, 3) != 0),
                      3'($urandom_range(0, 7)),
                      26'($urandom),
                      $urandom, $urandom, $urandom,
                      1'($urandom_range(0, 1)),
                      3'($urandom_range(0, 7)),
                      int'($urandom_range(0, 3)),
                      $urandom & 32'hFFFF_FFFC);
        end

        // reset in the middle of a read; the late ack must not load the PC
        instr_valid = 1'b1; br_op = 3'd4; ea = 32'hA00; flag_we = 1'b0;
        tick();
        chk("midrst_req_before", 32'(mem_bus.mem_req), 32'd1);
        tick();
        do_reset();
        #1;
        chk("midrst_pc", pc, 32'h0);
        chk("midrst_req", 32'(mem_bus.mem_req), 32'd0);
        chk("midrst_stall", 32'(stall), 32'd0);
        mem_bus.mem_ack = 1'b1; mem_bus.mem_rdata = 32'hDEAD_0000;
        tick();
        mem_bus.mem_ack = 1'b0;
        m_pc = m_pc + 32'd4;
        chk("late_ack_pc", pc, m_pc);
        chk("late_ack_req", 32'(mem_bus.mem_req), 32'd0);
        $display("midreset pc=%h", pc);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
